// File: rtl/terminal_qsys_pio_in_irq.sv
// Avalon-MM input PIO: synchronised status inputs, sticky per-bit edge capture,
// an interrupt mask and a registered level interrupt.
module terminal_qsys_pio_in_irq #(
  parameter int          WIDTH          = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int          EDGE_TYPE      = 0,
  parameter logic [31:0] IRQ_RESET_MASK = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Bus semantics: a write takes effect on the clk edge where chipselect=1 and
  // write_n=0; readdata is registered from address every cycle, with no wait states.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecapture;
  logic [WIDTH-1:0] r_irqmask;

  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_edgecapture_next;
  logic [WIDTH-1:0] w_irqmask_next;
  logic [31:0]      w_readdata_next;
  logic             w_write;
  logic             w_unused;

  assign w_sync_in = r_sync[SYNC_STAGES-1];
  assign w_write   = chipselect & ~write_n;
  assign w_wdata   = writedata[WIDTH-1:0];
  assign w_unused  = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync_in;
    end
  end

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_sync_in & ~r_prev;
      1:       w_edge = ~w_sync_in & r_prev;
      default: w_edge = w_sync_in ^ r_prev;
    endcase
  end

  // A new edge is OR-ed in after the clear, so it survives a same-cycle clear.
  always_comb begin
    w_clear            = '0;
    w_irqmask_next     = r_irqmask;
    if (w_write && (address == ADDR_EDGE)) begin
      w_clear = w_wdata;
    end
    if (w_write && (address == ADDR_MASK)) begin
      w_irqmask_next = w_wdata;
    end
    w_edgecapture_next = (r_edgecapture & ~w_clear) | w_edge;
  end

  always_comb begin
    w_readdata_next = '0;
    case (address)
      ADDR_DATA: w_readdata_next[WIDTH-1:0] = w_sync_in;
      ADDR_MASK: w_readdata_next[WIDTH-1:0] = r_irqmask;
      ADDR_EDGE: w_readdata_next[WIDTH-1:0] = r_edgecapture;
      default:   w_readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecapture <= '0;
      r_irqmask     <= IRQ_RESET_MASK[WIDTH-1:0];
      readdata      <= '0;
      irq           <= 1'b0;
    end else begin
      r_edgecapture <= w_edgecapture_next;
      r_irqmask     <= w_irqmask_next;
      readdata      <= w_readdata_next;
      irq           <= |(w_edgecapture_next & w_irqmask_next);
    end
  end

endmodule

// File: tb/tb_terminal_qsys_pio_in_irq.sv
// Bench for terminal_qsys_pio_in_irq: three parameter sets share one bus and
// are compared every cycle against a delay-line reference model.
module tb_terminal_qsys_pio_in_irq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in0;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  terminal_qsys_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0),
                             .IRQ_RESET_MASK(32'h0000_0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  terminal_qsys_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1),
                             .IRQ_RESET_MASK(32'h0000_015A)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  terminal_qsys_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2),
                             .IRQ_RESET_MASK(32'h0000_0081)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  // ---------------- reference model ----------------
  // hist[d][k] is the in_port value sampled k+1 edges before the coming edge,
  // so the synchronised view is hist[S-1] and its previous sample hist[S].
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  int          m_s  [3];
  int          m_et [3];
  logic [31:0] m_wm [3];
  logic [31:0] m_rm [3];
  logic [31:0] m_hist [3][5];
  logic [31:0] m_ec   [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_rd   [3];
  logic        m_irq  [3];

  function automatic logic [31:0] edges_of(int et, logic [31:0] s, logic [31:0] p);
    if (et == 0)      return s & ~p;
    else if (et == 1) return ~s & p;
    else              return s ^ p;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 5; j++) m_hist[d][j] = '0;
      m_ec[d]   = '0;
      m_mask[d] = m_rm[d] & m_wm[d];
      m_rd[d]   = '0;
      m_irq[d]  = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " rd0"},  rd0,           m_rd[0]);
    chk({tag, " rd1"},  rd1,           m_rd[1]);
    chk({tag, " rd2"},  rd2,           m_rd[2]);
    chk({tag, " irq0"}, {31'b0, irq0}, {31'b0, m_irq[0]});
    chk({tag, " irq1"}, {31'b0, irq1}, {31'b0, m_irq[1]});
    chk({tag, " irq2"}, {31'b0, irq2}, {31'b0, m_irq[2]});
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict from the current bus/inputs, take the edge, compare.
  task automatic step(input string tag);
    logic [31:0] ins [3];
    logic [31:0] n_ec [3];
    logic [31:0] n_mask [3];
    logic [31:0] n_rd [3];
    logic        n_irq [3];
    logic [31:0] s_in, pv, clr;
    logic        wr;
    ins[0] = in0;
    ins[1] = {24'h0, in1};
    ins[2] = {24'h0, in2};
    wr = chipselect && !write_n;
    for (int d = 0; d < 3; d++) begin
      s_in = m_hist[d][m_s[d]-1];
      pv   = m_hist[d][m_s[d]];
      n_mask[d] = (wr && address == 2'd2) ? (writedata & m_wm[d]) : m_mask[d];
      clr       = (wr && address == 2'd3) ? (writedata & m_wm[d]) : 32'h0;
      n_ec[d]   = (m_ec[d] & ~clr) | (edges_of(m_et[d], s_in, pv) & m_wm[d]);
      case (address)
        2'd0:    n_rd[d] = s_in;
        2'd2:    n_rd[d] = m_mask[d];
        2'd3:    n_rd[d] = m_ec[d];
        default: n_rd[d] = 32'h0;
      endcase
      n_irq[d] = (n_ec[d] & n_mask[d]) != 0;
      for (int j = 4; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
      m_hist[d][0] = ins[d] & m_wm[d];
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      m_ec[d]   = n_ec[d];
      m_mask[d] = n_mask[d];
      m_rd[d]   = n_rd[d];
      m_irq[d]  = n_irq[d];
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input logic [1:0] addr, input string tag);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = addr;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input string tag);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    step(tag);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Called at posedge+1; asserts reset between edges and checks it acts at once.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, " async"});
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all({tag, " held"});
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_s[0] = 2;  m_et[0] = 0;  m_wm[0] = 32'hFFFF_FFFF;  m_rm[0] = 32'h0000_0000;
    m_s[1] = 2;  m_et[1] = 1;  m_wm[1] = 32'h0000_00FF;  m_rm[1] = 32'h0000_015A;
    m_s[2] = 3;  m_et[2] = 2;  m_wm[2] = 32'h0000_00FF;  m_rm[2] = 32'h0000_0081;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in0 = 32'h0;  in1 = 8'h00;  in2 = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");
    chk("reset mask1", rd1, 32'h0);
    idle(3, 2'd2, "reset mask read");
    chk("reset mask1 value", rd1, 32'h0000_005A);

    // Test 1: data path latency and rising capture
    in0 = 32'h0000_00A5;
    idle(5, 2'd0, "t1 data");
    chk("t1 data value", rd0, 32'h0000_00A5);
    idle(2, 2'd3, "t1 edge");
    chk("t1 edge value", rd0, 32'h0000_00A5);

    // Test 2: masked capture raises irq, write-1-to-clear drops it
    in0 = 32'h0;
    idle(4, 2'd3, "t2 settle");
    bus_write(2'd3, 32'hFFFF_FFFF, "t2 clrall");
    bus_write(2'd2, 32'h0000_0001, "t2 mask");
    in0 = 32'h1;
    idle(3, 2'd3, "t2 pulse");
    in0 = 32'h0;
    idle(3, 2'd3, "t2 wait");
    chk("t2 irq0 high", {31'b0, irq0}, 32'h1);
    bus_write(2'd3, 32'h0000_0001, "t2 clr");
    idle(2, 2'd3, "t2 after");
    chk("t2 irq0 low", {31'b0, irq0}, 32'h0);

    // Test 3: edge on bit 4 coinciding with its clear
    bus_write(2'd2, 32'h0000_0010, "t3 mask");
    in0 = 32'h0000_0010;
    idle(2, 2'd3, "t3 edge");
    bus_write(2'd3, 32'h0000_0010, "t3 clr");
    idle(2, 2'd3, "t3 after");
    chk("t3 ec4 kept", {31'b0, rd0[4]}, 32'h1);
    chk("t3 irq0 kept", {31'b0, irq0}, 32'h1);

    // Test 4: falling capture on dut1, any-edge stickiness on dut2
    in1 = 8'hFF;
    idle(5, 2'd3, "t4 prep");
    bus_write(2'd3, 32'hFFFF_FFFF, "t4 clrall");
    in1 = 8'h0F;
    idle(5, 2'd3, "t4 fall");
    chk("t4 fall value", rd1, 32'h0000_00F0);
    in2 = 8'h01;
    idle(5, 2'd3, "t4 any rise");
    in2 = 8'h00;
    idle(5, 2'd3, "t4 any fall");
    chk("t4 any sticky", rd2, 32'h0000_0001);

    // Test 5: write truncation, reserved address, ignored data write
    bus_write(2'd2, 32'hFFFF_FFFF, "t5 mask");
    idle(2, 2'd2, "t5 mask rd");
    chk("t5 mask1 trunc", rd1, 32'h0000_00FF);
    idle(1, 2'd1, "t5 reserved");
    chk("t5 reserved", rd0, 32'h0);
    bus_write(2'd0, 32'h1234_5678, "t5 wr0");
    idle(2, 2'd2, "t5 after wr0");
    chk("t5 mask0 kept", rd0, 32'hFFFF_FFFF);

    // Test 6: reset while irq is asserted with edgecapture = 0x3
    in0 = 32'h0;
    idle(4, 2'd3, "t6 settle");
    bus_write(2'd3, 32'hFFFF_FFFF, "t6 clrall");
    bus_write(2'd2, 32'h0000_0003, "t6 mask");
    in0 = 32'h3;
    idle(4, 2'd3, "t6 capture");
    chk("t6 ec0 pre", rd0, 32'h0000_0003);
    chk("t6 irq0 pre", {31'b0, irq0}, 32'h1);
    do_reset("t6 reset");
    chk("t6 irq0 async", {31'b0, irq0}, 32'h0);
    in0 = 32'h0;
    idle(1, 2'd3, "t6 ec rd");
    chk("t6 ec0 cleared", rd0, 32'h0);
    idle(1, 2'd2, "t6 mask rd");
    chk("t6 mask0 reset", rd0, 32'h0);
    chk("t6 mask2 reset", rd2, 32'h0000_0081);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in0 = in0 ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) in1 = in1 ^ (8'h1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) in2 = 8'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
